key_conditioner: RTL and testbench

//   Conditions the raw DE1-SoC pushbuttons before they reach the cpu: clk, reset, s, load.
//   Per key: 2-FF synchronizer, counter-based debouncer, press/release edge detector.

---
 rtl/key_conditioner_if.sv | 23 ++
 rtl/key_conditioner.sv | 60 ++++++
 tb/tb_key_conditioner.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - pushbutton key inputs and conditioned outputs bundle
interface key_conditioner_if #(
  parameter int NKEYS = 4
);
  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] press_pulse;
  logic [NKEYS-1:0] release_pulse;

  modport master (
    output key_n,
    input  level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key_n,
    output level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-key synchronizer, counter debouncer and press/release strobes
module key_conditioner #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  key_conditioner_if.slave kif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] pressed;
  logic [NKEYS-1:0] level_q;
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] release_q;
  logic [CNT_W-1:0] cnt [NKEYS];

  // Keys are active-low; synchronizers reset to "released" so a key held
  // through reset is seen as a fresh press once reset lifts.
  assign pressed = ~sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '1;
      sync2     <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= kif.key_n;
      sync2     <= sync1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        if (pressed[i] == level_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_LAST) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else begin
          level_q[i]   <= pressed[i];
          cnt[i]       <= '0;
          press_q[i]   <= pressed[i];
          release_q[i] <= ~pressed[i];
        end
      end
    end
  end

  assign kif.level         = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed scoreboard bench for key_conditioner
module tb_key_conditioner;
  localparam int NKEYS = 4;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  key_conditioner_if #(.NKEYS(NKEYS)) kif ();

  key_conditioner #(
    .NKEYS(NKEYS),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kif(kif)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] lv, input logic [3:0] pr, input logic [3:0] rl);
    check($sformatf("%s.level", tag), kif.level, lv);
    check($sformatf("%s.press", tag), kif.press_pulse, pr);
    check($sformatf("%s.release", tag), kif.release_pulse, rl);
  endtask

  task automatic expect_n(input int n, input logic [3:0] lv, input logic [3:0] pr, input logic [3:0] rl);
    exp_t e;
    e.level = lv;
    e.press = pr;
    e.rel   = rl;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s.scoreboard: observed empty queue expected entry at cycle %0d", tag, i);
      end else begin
        e = exp_q.pop_front();
        check_all($sformatf("%s[%0d]", tag, i), e.level, e.press, e.rel);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    kif.key_n = 4'hF;
    repeat (2) @(negedge clk);

    // Asynchronous reset: outputs clear without a clock edge.
    reset_n = 1'b0;
    #1;
    check_all("reset_async", 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    check_all("reset_held", 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;

    // Clean press on key 0.
    kif.key_n = 4'hE;
    expect_n(5, 4'h0, 4'h0, 4'h0);
    expect_n(1, 4'h1, 4'h1, 4'h0);
    expect_n(2, 4'h1, 4'h0, 4'h0);
    run(8, "press");

    // Release key 0.
    kif.key_n = 4'hF;
    expect_n(5, 4'h1, 4'h0, 4'h0);
    expect_n(1, 4'h0, 4'h0, 4'h1);
    expect_n(2, 4'h0, 4'h0, 4'h0);
    run(8, "release");

    // Bounce on key 1: low 3, high 1, then low and held.
    kif.key_n = 4'hD;
    expect_n(3, 4'h0, 4'h0, 4'h0);
    run(3, "bounce_lo");
    kif.key_n = 4'hF;
    expect_n(1, 4'h0, 4'h0, 4'h0);
    run(1, "bounce_hi");
    kif.key_n = 4'hD;
    expect_n(5, 4'h0, 4'h0, 4'h0);
    expect_n(1, 4'h2, 4'h2, 4'h0);
    expect_n(3, 4'h2, 4'h0, 4'h0);
    run(9, "bounce_hold");
    kif.key_n = 4'hF;
    expect_n(5, 4'h2, 4'h0, 4'h0);
    expect_n(1, 4'h0, 4'h0, 4'h2);
    expect_n(1, 4'h0, 4'h0, 4'h0);
    run(7, "bounce_rel");

    // Simultaneous press and release of keys 0 and 3.
    kif.key_n = 4'h6;
    expect_n(5, 4'h0, 4'h0, 4'h0);
    expect_n(1, 4'h9, 4'h9, 4'h0);
    expect_n(1, 4'h9, 4'h0, 4'h0);
    run(7, "simul_press");
    kif.key_n = 4'hF;
    expect_n(5, 4'h9, 4'h0, 4'h0);
    expect_n(1, 4'h0, 4'h0, 4'h9);
    expect_n(1, 4'h0, 4'h0, 4'h0);
    run(7, "simul_rel");

    // Reset while key 0 is mid-count, key kept held through and after reset.
    kif.key_n = 4'hE;
    expect_n(4, 4'h0, 4'h0, 4'h0);
    run(4, "midcnt_pre");
    reset_n = 1'b0;
    #1;
    check_all("midcnt_reset", 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    check_all("midcnt_reset_held", 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    expect_n(5, 4'h0, 4'h0, 4'h0);
    expect_n(1, 4'h1, 4'h1, 4'h0);
    expect_n(4, 4'h1, 4'h0, 4'h0);
    run(10, "midcnt_post");

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
